// File: rtl/raster_tile_scheduler_pkg.sv
// Shared rasterizer definitions: default screen/tile geometry, the bounding
// box struct passed between setup stages, and signed min/max helpers.
package raster_tile_scheduler_pkg;

  localparam int SCREEN_W_DEF  = 640;
  localparam int SCREEN_H_DEF  = 480;
  localparam int LG_TILE_W_DEF = 4;
  localparam int LG_TILE_H_DEF = 4;

  // Inclusive bounds, signed so off-screen (negative) coordinates survive.
  typedef struct packed {
    logic signed [31:0] xmin;
    logic signed [31:0] xmax;
    logic signed [31:0] ymin;
    logic signed [31:0] ymax;
  } bbox_t;

  function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [31:0] smin(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/raster_tile_scheduler_bbox_clip.sv
// Combinational clamp of a signed bbox to the screen rectangle.
// Ports:
//   box_in  - raw inclusive bbox (any signed coordinates)
//   box_out - bbox clamped to [0,SCREEN_W-1] x [0,SCREEN_H-1]
//   empty   - clamped box has no pixels (off-screen or degenerate)
module raster_tile_scheduler_bbox_clip
  import raster_tile_scheduler_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  bbox_t box_in,
  output bbox_t box_out,
  output logic  empty
);

  localparam logic signed [31:0] XLIM = SCREEN_W - 1;
  localparam logic signed [31:0] YLIM = SCREEN_H - 1;

  assign box_out.xmin = smax(box_in.xmin, 32'sd0);
  assign box_out.xmax = smin(box_in.xmax, XLIM);
  assign box_out.ymin = smax(box_in.ymin, 32'sd0);
  assign box_out.ymax = smin(box_in.ymax, YLIM);

  assign empty = ($signed(box_out.xmin) > $signed(box_out.xmax)) ||
                 ($signed(box_out.ymin) > $signed(box_out.ymax));

endmodule

// File: rtl/raster_tile_scheduler.sv
// Splits one triangle bbox into screen-aligned tiles and hands them one at a
// time to fragment_generator in row-major order.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   req_valid/req_ready  - bbox handshake (ready only when idle)
//   req_x/ymin/max       - signed inclusive bbox
//   fg_start, fg_done    - per-tile start pulse out / completion pulse in
//   fg_x/ymin/max        - tile-clipped bounds, held from fg_start to fg_done
//   bbox_done/bbox_empty - bbox retired; empty flags nothing was drawn
//   tiles_issued         - saturating count of fg_start for this bbox
//   busy                 - not idle
module raster_tile_scheduler
  import raster_tile_scheduler_pkg::*;
#(
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int LG_TILE_W = LG_TILE_W_DEF,
  parameter int LG_TILE_H = LG_TILE_H_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic signed [31:0] req_xmin,
  input  logic signed [31:0] req_xmax,
  input  logic signed [31:0] req_ymin,
  input  logic signed [31:0] req_ymax,
  output logic               fg_start,
  output logic signed [31:0] fg_xmin,
  output logic signed [31:0] fg_xmax,
  output logic signed [31:0] fg_ymin,
  output logic signed [31:0] fg_ymax,
  input  logic               fg_done,
  output logic               bbox_done,
  output logic               bbox_empty,
  output logic [15:0]        tiles_issued,
  output logic               busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLIP  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;

  localparam logic signed [31:0] TW    = 1 << LG_TILE_W;
  localparam logic signed [31:0] TH    = 1 << LG_TILE_H;
  localparam logic signed [31:0] XMASK = (1 << LG_TILE_W) - 1;
  localparam logic signed [31:0] YMASK = (1 << LG_TILE_H) - 1;

  logic [2:0]         state;
  bbox_t              raw_q;    // bbox as accepted
  bbox_t              clip_q;   // screen-clamped bbox
  bbox_t              clip_box;
  logic               clip_empty;
  logic signed [31:0] tx_q, ty_q;  // current tile origin (aligned)
  logic               more_x, more_y;

  raster_tile_scheduler_bbox_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .box_in  (raw_q),
    .box_out (clip_box),
    .empty   (clip_empty)
  );

  assign more_x = (tx_q + TW) <= $signed(clip_q.xmax);
  assign more_y = (ty_q + TH) <= $signed(clip_q.ymax);

  // Bounds derive only from registers that stay put through ISSUE and WAIT,
  // so they are stable for the whole tile without a separate output stage.
  assign fg_xmin = smax(clip_q.xmin, tx_q);
  assign fg_xmax = smin(clip_q.xmax, tx_q + TW - 32'sd1);
  assign fg_ymin = smax(clip_q.ymin, ty_q);
  assign fg_ymax = smin(clip_q.ymax, ty_q + TH - 32'sd1);

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign fg_start   = (state == S_ISSUE);
  assign bbox_empty = (state == S_CLIP) && clip_empty;
  assign bbox_done  = bbox_empty || ((state == S_NEXT) && !more_x && !more_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      raw_q        <= '0;
      clip_q       <= '0;
      tx_q         <= '0;
      ty_q         <= '0;
      tiles_issued <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          raw_q.xmin   <= req_xmin;
          raw_q.xmax   <= req_xmax;
          raw_q.ymin   <= req_ymin;
          raw_q.ymax   <= req_ymax;
          tiles_issued <= '0;
          state        <= S_CLIP;
        end
        S_CLIP: if (clip_empty) begin
          state <= S_IDLE;
        end else begin
          clip_q <= clip_box;
          // Clamped mins are non-negative, so masking aligns down.
          tx_q   <= clip_box.xmin & ~XMASK;
          ty_q   <= clip_box.ymin & ~YMASK;
          state  <= S_ISSUE;
        end
        S_ISSUE: begin
          if (tiles_issued != 16'hFFFF) tiles_issued <= tiles_issued + 16'd1;
          state <= S_WAIT;
        end
        S_WAIT: if (fg_done) state <= S_NEXT;
        S_NEXT: begin
          if (more_x) begin
            tx_q  <= tx_q + TW;
            state <= S_ISSUE;
          end else if (more_y) begin
            tx_q  <= clip_q.xmin & ~XMASK;
            ty_q  <= ty_q + TH;
            state <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_tile_scheduler.sv
module tb_raster_tile_scheduler;

  localparam int SW = 640;
  localparam int SH = 480;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic signed [31:0] req_xmin = '0, req_xmax = '0, req_ymin = '0, req_ymax = '0;
  logic               fg_start;
  logic signed [31:0] fg_xmin, fg_xmax, fg_ymin, fg_ymax;
  logic               fg_done = 1'b0;
  logic               bbox_done, bbox_empty, busy;
  logic [15:0]        tiles_issued;

  raster_tile_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_xmin(req_xmin), .req_xmax(req_xmax), .req_ymin(req_ymin), .req_ymax(req_ymax),
    .fg_start(fg_start), .fg_xmin(fg_xmin), .fg_xmax(fg_xmax), .fg_ymin(fg_ymin),
    .fg_ymax(fg_ymax), .fg_done(fg_done), .bbox_done(bbox_done),
    .bbox_empty(bbox_empty), .tiles_issued(tiles_issued), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int xmin; int xmax; int ymin; int ymax; bit first; int acc; } tile_t;
  typedef struct { bit empty; int ntiles; int acc; } done_t;

  tile_t exp_tiles[$];
  done_t exp_done[$];
  tile_t mt;
  done_t md;

  int n_chk = 0, n_fail = 0;
  bit active = 0, outstanding = 0, mon_off = 0, fg_hold = 0;
  int act_cyc = 0, last_done_cyc = -100, fgdone_cyc = -100, fg_delay_fix = 0;
  int fg_dly;
  logic signed [31:0] s_x0, s_x1, s_y0, s_y1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: clamp to screen, then enumerate every 16x16 grid cell that the
  // clamped box touches, rows outer, columns inner.
  function automatic void model_push(int x0, int x1, int y0, int y1, int acc);
    int cx0 = (x0 < 0) ? 0 : x0;
    int cx1 = (x1 > SW - 1) ? SW - 1 : x1;
    int cy0 = (y0 < 0) ? 0 : y0;
    int cy1 = (y1 > SH - 1) ? SH - 1 : y1;
    int n = 0;
    bit f = 1;
    if (cx0 > cx1 || cy0 > cy1) begin
      exp_done.push_back('{empty: 1, ntiles: 0, acc: acc});
      return;
    end
    for (int ty = (cy0 / 16) * 16; ty <= cy1; ty += 16)
      for (int tx = (cx0 / 16) * 16; tx <= cx1; tx += 16) begin
        exp_tiles.push_back('{xmin: (cx0 > tx) ? cx0 : tx,
                              xmax: (cx1 < tx + 15) ? cx1 : tx + 15,
                              ymin: (cy0 > ty) ? cy0 : ty,
                              ymax: (cy1 < ty + 15) ? cy1 : ty + 15,
                              first: f, acc: acc});
        f = 0;
        n++;
      end
    exp_done.push_back('{empty: 0, ntiles: (n > 65535) ? 65535 : n, acc: acc});
  endfunction

  // Monitor: pops expectations whenever the DUT presents a start or done.
  always @(negedge clk) begin
    if (!mon_off && !rst) begin
      if (active && cyc > act_cyc) chk("req_ready_low_while_busy", req_ready, 0);
      if (bbox_empty) chk("bbox_empty_qualified", bbox_done, 1);
      if (fg_start) begin
        chk("single_outstanding", outstanding, 0);
        if (exp_tiles.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_fg_start: got fg_start, expected none (cycle %0d)", cyc);
        end else begin
          mt = exp_tiles.pop_front();
          chk("fg_xmin", fg_xmin, mt.xmin);
          chk("fg_xmax", fg_xmax, mt.xmax);
          chk("fg_ymin", fg_ymin, mt.ymin);
          chk("fg_ymax", fg_ymax, mt.ymax);
          chk("fg_start_cycle", cyc, mt.first ? mt.acc + 2 : fgdone_cyc + 2);
        end
        outstanding = 1;
      end
      if (bbox_done) begin
        if (exp_done.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_bbox_done: got bbox_done, expected none (cycle %0d)", cyc);
        end else begin
          md = exp_done.pop_front();
          chk("bbox_empty", bbox_empty, md.empty);
          chk("tiles_issued", tiles_issued, md.ntiles);
          chk("bbox_done_cycle", cyc, md.empty ? md.acc + 1 : fgdone_cyc + 1);
          chk("tiles_pending_at_done", exp_tiles.size(), 0);
        end
        active = 0;
        last_done_cyc = cyc;
      end
    end
  end

  // fragment_generator stand-in: random latency, checks bounds are held.
  initial forever begin
    @(negedge clk);
    if (fg_start && !fg_hold && !rst) begin
      fg_dly = (fg_delay_fix > 0) ? fg_delay_fix : int'($urandom_range(1, 6));
      s_x0 = fg_xmin; s_x1 = fg_xmax; s_y0 = fg_ymin; s_y1 = fg_ymax;
      repeat (fg_dly) @(negedge clk);
      chk("fg_bounds_stable", (fg_xmin == s_x0 && fg_xmax == s_x1 &&
                               fg_ymin == s_y0 && fg_ymax == s_y1), 1);
      fg_done = 1'b1;
      fgdone_cyc = cyc;
      outstanding = 0;
      @(negedge clk);
      fg_done = 1'b0;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_fg_start"}, fg_start, 0);
    chk({tag, "_bbox_done"}, bbox_done, 0);
    chk({tag, "_bbox_empty"}, bbox_empty, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tiles_issued"}, tiles_issued, 0);
    chk({tag, "_fg_bounds_zero"}, (fg_xmin == 0 && fg_xmax == 0 &&
                                   fg_ymin == 0 && fg_ymax == 0), 1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting cycle.
  task automatic send(input int x0, input int x1, input int y0, input int y1, input bit held);
    int budget = 0;
    req_xmin = x0; req_xmax = x1; req_ymin = y0; req_ymax = y1;
    req_valid = 1'b1;
    while (!req_ready) begin
      @(negedge clk);
      budget++;
      if (budget > 3000) begin
        $display("FAIL accept_timeout: req_ready never rose within 3000 cycles");
        $fatal(1, "stopping");
      end
    end
    if (held) chk("accept_after_done", cyc, last_done_cyc + 1);
    act_cyc = cyc;
    active = 1;
    model_push(x0, x1, y0, y1, cyc);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int budget = 0;
    req_valid = 1'b0;
    while ((exp_done.size() != 0 || active) && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 3000) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: %0d bboxes still pending after 3000 cycles", exp_done.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "stopping");
  end

  initial begin
    int x0, x1, y0, y1;
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("after_reset");

    // Directed cases
    send(0, 15, 0, 15, 0);      wait_idle();
    send(10, 20, 5, 18, 0);     wait_idle();
    send(-5, 3, -3, 2, 0);      wait_idle();
    send(700, 800, 10, 20, 0);  wait_idle();
    send(630, 700, 470, 500, 0); wait_idle();
    send(5, 4, 0, 10, 0);       wait_idle();

    // Back-to-back requests against a slow fragment_generator
    fg_delay_fix = 50;
    send(0, 20, 0, 5, 0);
    send(30, 40, 30, 40, 1);
    send(-10, -1, 0, 5, 1);
    send(100, 100, 100, 100, 1);
    wait_idle();
    fg_delay_fix = 0;

    // Reset while a tile is in flight, then a stray fg_done
    fg_hold = 1;
    send(0, 15, 0, 15, 0);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !outstanding; i++) @(negedge clk);
    chk("reset_test_tile_started", outstanding, 1);
    repeat (2) @(negedge clk);
    mon_off = 1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("mid_reset");
    exp_tiles.delete();
    exp_done.delete();
    active = 0;
    outstanding = 0;
    mon_off = 0;
    fg_done = 1'b1;
    @(negedge clk);
    fg_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stray_done_no_bbox_done", bbox_done, 0);
      chk("stray_done_idle", busy, 0);
      @(negedge clk);
    end
    fg_hold = 0;
    send(10, 20, 5, 18, 0);
    wait_idle();

    // Randomized bboxes, mixed gaps and back-to-back
    for (int i = 0; i < 40; i++) begin
      bit held;
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      held = req_valid;
      x0 = int'($urandom_range(0, 760)) - 60;
      x1 = x0 + int'($urandom_range(0, 50));
      y0 = int'($urandom_range(0, 560)) - 60;
      y1 = y0 + int'($urandom_range(0, 50));
      if ($urandom_range(0, 7) == 0) x1 = x0 - int'($urandom_range(1, 5));
      if ($urandom_range(0, 9) == 0) begin x0 = -100000; x1 = 100000; y1 = y0 + 3; end
      send(x0, x1, y0, y1, held);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/raster_tile_scheduler.md
Name: raster_tile_scheduler

Overview:
- Sits between triangle setup and fragment_generator.
- Accepts one clipped-or-unclipped triangle bounding box per request, clamps it to the screen, and splits it into screen-aligned TILE_W x TILE_H tiles.
- Issues one start per non-empty tile to fragment_generator, waits for that tile's done pulse, then advances in row-major order.
- Reports per-bbox completion so setup can retire the triangle.

Parameters:
- SCREEN_W, 640, screen width in pixels; legal x is 0..SCREEN_W-1.
- SCREEN_H, 480, screen height in pixels; legal y is 0..SCREEN_H-1.
- LG_TILE_W, 4, log2 tile width (TILE_W = 16).
- LG_TILE_H, 4, log2 tile height (TILE_H = 16).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  bbox request valid.
- req_ready  out  1  scheduler can accept a bbox (high only in IDLE).
- req_xmin, req_xmax, req_ymin, req_ymax  in  32 each  signed inclusive bbox bounds.
- fg_start  out  1  one-cycle start pulse to fragment_generator.
- fg_xmin, fg_xmax, fg_ymin, fg_ymax  out  32 each  inclusive tile-clipped bounds; stable from fg_start until fg_done.
- fg_done  in  1  one-cycle completion pulse from fragment_generator.
- bbox_done  out  1  one-cycle pulse: all tiles of the current bbox finished.
- bbox_empty  out  1  qualifies bbox_done: bbox was fully off-screen or degenerate.
- tiles_issued  out  16  fg_start count for the current bbox; cleared on accept, saturates at 0xFFFF.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: req_ready=1, fg_start=0, bbox_done=0, bbox_empty=0, busy=0, tiles_issued=0, fg bounds=0, state=IDLE.
- States: IDLE, CLIP, ISSUE, WAIT, NEXT.
- IDLE:
  - req_ready=1.
  - req_valid&&req_ready latches the bbox, clears tiles_issued, goes to CLIP.
- CLIP (1 cycle), signed compares throughout:
  - cxmin=max(xmin,0), cxmax=min(xmax,SCREEN_W-1); same for y with SCREEN_H.
  - If cxmin>cxmax or cymin>cymax: pulse bbox_done with bbox_empty=1, go to IDLE.
  - Otherwise set tile origin tx=cxmin with low LG_TILE_W bits cleared, ty=cymin with low LG_TILE_H bits cleared; go to ISSUE.
- ISSUE (1 cycle):
  - fg_xmin=max(cxmin,tx), fg_xmax=min(cxmax,tx+TILE_W-1); same for y.
  - fg_start=1, tiles_issued++, go to WAIT.
  - Latency: fg_start is asserted exactly 2 cycles after the accepting edge.
- WAIT: hold bounds; on fg_done go to NEXT. fg_done outside WAIT is ignored.
- NEXT (1 cycle):
  - If tx+TILE_W<=cxmax: tx+=TILE_W, go to ISSUE.
  - Else if ty+TILE_H<=cymax: tx reset to aligned cxmin, ty+=TILE_H, go to ISSUE.
  - Else pulse bbox_done (bbox_empty=0), go to IDLE.
- Every issued tile is non-empty by construction.
- At most one tile is outstanding; fragment_generator is never started while a tile is in flight.
- New request arriving in the same cycle as the final bbox_done: not accepted until IDLE (req_ready is low during NEXT); accepted the following cycle if still valid.
- Arithmetic: tile math in 32-bit signed. Screen dimensions bound all sums below 2^31, so no overflow.
- Reset mid-operation:
  - Returns to IDLE the next cycle with all outputs at reset values.
  - The in-flight tile is abandoned; fragment_generator shares rst.

Decomposition:
- Add SCREEN_W, SCREEN_H, LG_TILE_W, LG_TILE_H defaults and a bbox_t struct (xmin, xmax, ymin, ymax, 32-bit signed) to rasterizer.vh / the shared package.
- Define the scheduler state enum locally.
- One natural sub-module: bbox_clip (combinational signed clamp plus empty detect), reusable by later setup stages.

Test Plan:
- bbox (0,0)-(15,15) -> one fg_start 2 cycles after accept with bounds (0..15, 0..15); bbox_done 1 cycle after fg_done; tiles_issued=1.
- bbox (10,5)-(20,18) -> four fg_starts in order x10..15/y5..15, x16..20/y5..15, x10..15/y16..18, x16..20/y16..18; bbox_done after the 4th fg_done; tiles_issued=4.
- bbox (-5,-3)-(3,2) -> single tile (0..3, 0..2).
- bbox (700,10)-(800,20) -> no fg_start; bbox_done=1 and bbox_empty=1 one cycle after accept.
- Hold req_valid high with 2 bboxes queued; fg_done delayed 50 cycles -> req_ready stays low throughout; second bbox is accepted the cycle after the first bbox_done.
- rst asserted in WAIT, then fg_done pulsed -> outputs at reset values next cycle; stray fg_done causes no bbox_done; next request behaves normally.
